// File: rtl/nnl_dense_seq_pkg.sv
// Shared definitions for the time-multiplexed dense layer: activation and
// FSM encodings plus constant-width helpers used to size ports and counters.
package nnl_pkg;

    typedef enum logic [1:0] {
        ACT_ID   = 2'd0,
        ACT_RELU = 2'd1,
        ACT_HSIG = 2'd2,
        ACT_STEP = 2'd3
    } act_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index width that is never zero, so single-entry arrays still get a bit.
    function automatic int addr_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/nnl_dense_seq_if.sv
// Bus bundle for one dense layer: start/busy/done control, input vector,
// weight-store write port, output vector and an FSM debug view.
//
// Handshake: start is sampled only on an edge where busy=0; that edge latches
// x and act_sel and raises busy. busy falls on the final edge of the
// evaluation, which also raises done for exactly one cycle. A start presented
// during that done cycle is accepted. Weight writes (w_we) land only on edges
// where busy=0 and are otherwise dropped. y is valid as a whole from the done
// pulse until the next accepted start.
interface nnl_dense_seq_if #(
    parameter int WIDTH = 16,
    parameter int N     = 2,
    parameter int M     = 4
);
    localparam int AW = nnl_pkg::addr_w(M * (N + 1));

    logic                 start;
    logic [N*WIDTH-1:0]   x;
    logic [1:0]           act_sel;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic [WIDTH-1:0]     w_data;
    logic [M*WIDTH-1:0]   y;
    logic                 busy;
    logic                 done;
    nnl_pkg::state_t      state;

    modport master (
        output start, x, act_sel, w_we, w_addr, w_data,
        input  y, busy, done, state
    );

    modport slave (
        input  start, x, act_sel, w_we, w_addr, w_data,
        output y, busy, done, state
    );

endinterface

// File: rtl/nnl_dense_seq_act.sv
// Activation and narrowing stage: takes the accumulator already shifted back
// to FRAC fractional bits and returns a WIDTH-bit Q value.
// Build option NNL_SAT_EN: when defined, results outside the WIDTH-bit signed
// range saturate; otherwise the low WIDTH bits are kept (wrap-around).
module nnl_act
    import nnl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACCW  = 34
) (
    input  logic signed [ACCW-1:0] v,
    input  act_t                   act_sel,
    output logic [WIDTH-1:0]       r
);
    localparam logic signed [ACCW-1:0] ONE  = {{(ACCW-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [ACCW-1:0] HALF = ONE >>> 1;
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [ACCW-1:0] a;
    logic signed [ACCW-1:0] hs;

    // Apply the selected activation at full precision, then narrow.
    always_comb begin
        a  = v;
        hs = (v >>> 2) + HALF;
        case (act_sel)
            ACT_ID:   a = v;
            ACT_RELU: a = (v < 0) ? '0 : v;
            ACT_HSIG: begin
                if (hs < 0)        a = '0;
                else if (hs > ONE) a = ONE;
                else               a = hs;
            end
            ACT_STEP: a = (v >= 0) ? ONE : '0;
            default:  a = v;
        endcase
`ifdef NNL_SAT_EN
        if (a > MAXV)      r = MAXV[WIDTH-1:0];
        else if (a < MINV) r = MINV[WIDTH-1:0];
        else               r = a[WIDTH-1:0];
`else
        r = a[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/nnl_dense_seq.sv
// Time-multiplexed fixed-point dense layer y[i] = act(sum_j W[i][j]*x[j] + b[i])
// with one MAC, a register-file weight store and a start/done handshake.
// Build option NNL_SAT_EN (inside nnl_act) selects saturating narrowing.
module nnl_dense_seq
    import nnl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int N     = 2,
    parameter int M     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    nnl_dense_seq_if.slave bus
);
    localparam int DEPTH = M * (N + 1);
    localparam int AW    = addr_w(DEPTH);
    localparam int IW    = addr_w(M);
    localparam int JW    = addr_w(N);
    localparam int ACCW  = 2 * WIDTH + clog2(N + 1);

    state_t                   state, state_nxt;
    logic signed [WIDTH-1:0]  mem [DEPTH];
    logic signed [WIDTH-1:0]  xq [N];
    act_t                     act_q;
    logic [AW-1:0]            ptr;
    logic [IW-1:0]            i_q;
    logic [JW-1:0]            j_q;
    logic signed [ACCW-1:0]   acc;
    logic [WIDTH-1:0]         y_q [M];
    logic                     busy_q, done_q;

    // A write that lands on the same edge as an accepted start must not be
    // seen by that evaluation: remember the displaced value for the run.
    logic                     ovr_v;
    logic [AW-1:0]            ovr_addr;
    logic signed [WIDTH-1:0]  ovr_data;

    logic                     w_fire;
    logic [AW-1:0]            b_addr;
    logic signed [WIDTH-1:0]  w_rd, b_rd;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]   shifted;
    logic [WIDTH-1:0]         act_y;

    // Weight/bias reads with the same-edge override, and the MAC product.
    always_comb begin
        w_fire = (state == IDLE) && bus.w_we && (32'(bus.w_addr) < DEPTH);
        w_rd   = mem[ptr];
        if (state != IDLE && ovr_v && ptr == ovr_addr) w_rd = ovr_data;
        b_addr = (state == IDLE) ? AW'(N) : ptr + AW'(N + 1);
        b_rd   = mem[b_addr];
        if (state != IDLE && ovr_v && b_addr == ovr_addr) b_rd = ovr_data;
        prod   = (2*WIDTH)'(w_rd) * (2*WIDTH)'(xq[j_q]);
    end

    assign shifted = acc >>> FRAC;

    nnl_act #(.WIDTH(WIDTH), .FRAC(FRAC), .ACCW(ACCW)) u_act (
        .v       (shifted),
        .act_sel (act_q),
        .r       (act_y)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: N MAC edges then one FIN edge per neuron.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = MAC;
            MAC:     if (j_q == JW'(N - 1)) state_nxt = FIN;
            FIN:     state_nxt = (i_q == IW'(M - 1)) ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: weight store, operand latch, accumulator, counters, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            for (int k = 0; k < N; k++)     xq[k]  <= '0;
            for (int k = 0; k < M; k++)     y_q[k] <= '0;
            act_q    <= ACT_ID;
            acc      <= '0;
            ptr      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_v    <= 1'b0;
            ovr_addr <= '0;
            ovr_data <= '0;
        end else begin
            done_q <= 1'b0;
            if (w_fire) mem[bus.w_addr] <= bus.w_data;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < N; k++) xq[k] <= bus.x[k*WIDTH +: WIDTH];
                        act_q    <= act_t'(bus.act_sel);
                        acc      <= ACCW'(b_rd) <<< FRAC;
                        ptr      <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        busy_q   <= 1'b1;
                        ovr_v    <= w_fire;
                        ovr_addr <= bus.w_addr;
                        ovr_data <= mem[bus.w_addr];
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    ptr <= ptr + AW'(1);
                    j_q <= j_q + JW'(1);
                end
                FIN: begin
                    y_q[i_q] <= act_y;
                    if (i_q == IW'(M - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        ovr_v  <= 1'b0;
                    end else begin
                        acc <= ACCW'(b_rd) <<< FRAC;
                        ptr <= ptr + AW'(1);
                        i_q <= i_q + IW'(1);
                        j_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state;

    for (genvar g = 0; g < M; g++) begin : g_y
        assign bus.y[g*WIDTH +: WIDTH] = y_q[g];
    end

endmodule

// File: tb/tb_nnl_dense_seq.sv
// Directed bench for nnl_dense_seq: a 2-1 instance (u_a) for activation and
// arithmetic cases and a 2-3 instance (u_b) for handshake, back-to-back and
// reset behaviour.
module tb_nnl_dense_seq;
    import nnl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    nnl_dense_seq_if #(.WIDTH(16), .N(2), .M(1)) bus_a ();
    nnl_dense_seq_if #(.WIDTH(16), .N(2), .M(3)) bus_b ();

    nnl_dense_seq #(.WIDTH(16), .FRAC(8), .N(2), .M(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    nnl_dense_seq #(.WIDTH(16), .FRAC(8), .N(2), .M(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // ---------------- driver tasks ----------------
    task automatic write_a(input int addr, input logic [15:0] data);
        bus_a.w_we = 1'b1; bus_a.w_addr = 2'(addr); bus_a.w_data = data;
        @(posedge clk); #1;
        bus_a.w_we = 1'b0;
    endtask

    task automatic write_b(input int addr, input logic [15:0] data);
        bus_b.w_we = 1'b1; bus_b.w_addr = 4'(addr); bus_b.w_data = data;
        @(posedge clk); #1;
        bus_b.w_we = 1'b0;
    endtask

    // Start one run on u_a; lat = edges from start to done (0 on timeout).
    task automatic run_a(input logic [15:0] x0, x1, input logic [1:0] act, output int lat);
        bus_a.x = {x1, x0}; bus_a.act_sel = act; bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus_a.done === 1'b1) begin lat = k; break; end
        end
    endtask

    // Start one run on u_b; optional mid-run start/write injection.
    task automatic run_b(input logic [15:0] x0, x1, input logic [1:0] act, input bit inject,
                         output int lat, output logic busy_e0);
        bus_b.x = {x1, x0}; bus_b.act_sel = act; bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0; bus_b.w_we = 1'b0;
        busy_e0 = bus_b.busy;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (inject && k == 4) begin
                bus_b.start = 1'b1; bus_b.x = '0;
                bus_b.w_we = 1'b1; bus_b.w_addr = 4'd0; bus_b.w_data = 16'h0500;
            end else if (inject && k == 5) begin
                bus_b.start = 1'b0; bus_b.w_we = 1'b0;
            end
            @(posedge clk); #1;
            if (bus_b.done === 1'b1) begin lat = k; break; end
        end
        bus_b.start = 1'b0; bus_b.w_we = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_a.start = 0; bus_a.x = '0; bus_a.act_sel = 0; bus_a.w_we = 0; bus_a.w_addr = '0; bus_a.w_data = '0;
        bus_b.start = 0; bus_b.x = '0; bus_b.act_sel = 0; bus_b.w_we = 0; bus_b.w_addr = '0; bus_b.w_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus_a.y !== 16'h0) begin errors++; $display("FAIL reset_y_a got %h exp 0000", bus_a.y); end
        vectors++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b exp 0", bus_a.busy); end
        vectors++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b exp 0", bus_a.done); end
        vectors++; if (bus_b.y !== 48'h0) begin errors++; $display("FAIL reset_y_b got %h exp 0", bus_b.y); end
        vectors++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b exp 0", bus_b.busy); end
        vectors++; if (bus_b.done !== 1'b0) begin errors++; $display("FAIL reset_done_b got %b exp 0", bus_b.done); end
    endtask

    task automatic test_step();
        logic [15:0] tx0 [3] = '{16'h0000, 16'h0100, 16'h0100};
        logic [15:0] tx1 [3] = '{16'h0000, 16'h0000, 16'h0100};
        logic [15:0] ty  [3] = '{16'h0000, 16'h0100, 16'h0100};
        int lat;
        write_a(0, 16'h0100); write_a(1, 16'h0100); write_a(2, 16'hFF80);
        for (int k = 0; k < 3; k++) begin
            run_a(tx0[k], tx1[k], 2'd3, lat);
            vectors++; if (bus_a.y !== ty[k]) begin errors++; $display("FAIL step_y[%0d] got %h exp %h", k, bus_a.y, ty[k]); end
            vectors++; if (lat !== 3) begin errors++; $display("FAIL step_latency[%0d] got %0d exp 3", k, lat); end
        end
        @(posedge clk); #1;
        vectors++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", bus_a.done); end
    endtask

    task automatic test_identity_relu();
        int lat;
        run_a(16'h0100, 16'h0100, 2'd0, lat);
        vectors++; if (bus_a.y !== 16'h0180) begin errors++; $display("FAIL identity got %h exp 0180", bus_a.y); end
        write_a(2, 16'hFC00);
        run_a(16'h0100, 16'h0100, 2'd1, lat);
        vectors++; if (bus_a.y !== 16'h0000) begin errors++; $display("FAIL relu_neg got %h exp 0000", bus_a.y); end
        run_a(16'h0100, 16'h0100, 2'd0, lat);
        vectors++; if (bus_a.y !== 16'hFE00) begin errors++; $display("FAIL identity_neg got %h exp fe00", bus_a.y); end
    endtask

    task automatic test_truncation();
        int lat;
        write_a(0, 16'h0080); write_a(1, 16'h0000); write_a(2, 16'h0000);
        run_a(16'hFF01, 16'h0000, 2'd0, lat);
        vectors++; if (bus_a.y !== 16'hFF80) begin errors++; $display("FAIL floor_shift got %h exp ff80", bus_a.y); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [15:0] exp_y;
`ifdef NNL_SAT_EN
        exp_y = 16'h7FFF;
`else
        exp_y = 16'hC800;
`endif
        write_a(0, 16'h0100); write_a(1, 16'h0100); write_a(2, 16'h0000);
        run_a(16'h6400, 16'h6400, 2'd0, lat);
        vectors++; if (bus_a.y !== exp_y) begin errors++; $display("FAIL overflow got %h exp %h", bus_a.y, exp_y); end
    endtask

    task automatic test_hsig();
        logic [15:0] tx [4] = '{16'h0000, 16'h0400, 16'hF800, 16'h0100};
        logic [15:0] ty [4] = '{16'h0080, 16'h0100, 16'h0000, 16'h00C0};
        int lat;
        write_a(0, 16'h0100); write_a(1, 16'h0000); write_a(2, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            run_a(tx[k], 16'h0000, 2'd2, lat);
            vectors++; if (bus_a.y !== ty[k]) begin errors++; $display("FAIL hsig[%0d] got %h exp %h", k, bus_a.y, ty[k]); end
        end
    endtask

    task automatic test_handshake();
        logic [15:0] tw [9] = '{16'h0100, 16'h0100, 16'h0000,
                                16'h0100, 16'hFF00, 16'h0000,
                                16'h0200, 16'h0000, 16'h0100};
        int lat;
        logic b0;
        for (int k = 0; k < 9; k++) write_b(k, tw[k]);
        run_b(16'h0300, 16'h0100, 2'd0, 1'b1, lat, b0);
        vectors++; if (bus_b.y !== {16'h0700, 16'h0200, 16'h0400}) begin errors++; $display("FAIL hs_y got %h exp 070002000400", bus_b.y); end
        vectors++; if (lat !== 9) begin errors++; $display("FAIL hs_latency got %0d exp 9", lat); end
        vectors++; if (b0 !== 1'b1) begin errors++; $display("FAIL hs_busy_e0 got %b exp 1", b0); end
        @(posedge clk); #1;
        vectors++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL hs_ignored_start got busy %b exp 0", bus_b.busy); end
    endtask

    task automatic test_write_with_start();
        int lat;
        logic b0;
        bus_b.w_we = 1'b1; bus_b.w_addr = 4'd0; bus_b.w_data = 16'h0200;
        run_b(16'h0300, 16'h0100, 2'd0, 1'b0, lat, b0);
        vectors++; if (bus_b.y !== {16'h0700, 16'h0200, 16'h0400}) begin errors++; $display("FAIL wr_start_old got %h exp 070002000400", bus_b.y); end
        @(posedge clk); #1;
        run_b(16'h0300, 16'h0100, 2'd0, 1'b0, lat, b0);
        vectors++; if (bus_b.y !== {16'h0700, 16'h0200, 16'h0700}) begin errors++; $display("FAIL wr_start_new got %h exp 070002000700", bus_b.y); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic b0;
        run_b(16'h0300, 16'h0100, 2'd0, 1'b0, lat, b0);
        vectors++; if (bus_b.y !== {16'h0700, 16'h0200, 16'h0700}) begin errors++; $display("FAIL b2b_first got %h exp 070002000700", bus_b.y); end
        run_b(16'h0100, 16'h0100, 2'd0, 1'b0, lat, b0);
        vectors++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", b0); end
        vectors++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got %0d exp 9", lat); end
        vectors++; if (bus_b.y !== {16'h0300, 16'h0000, 16'h0300}) begin errors++; $display("FAIL b2b_second got %h exp 030000000300", bus_b.y); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int dones;
        logic b0;
        bus_b.x = {16'h0100, 16'h0300}; bus_b.act_sel = 2'd0; bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (bus_b.y !== 48'h0) begin errors++; $display("FAIL mid_reset_y got %h exp 0", bus_b.y); end
        vectors++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", bus_b.busy); end
        vectors++; if (bus_a.y !== 16'h0) begin errors++; $display("FAIL mid_reset_y_a got %h exp 0", bus_a.y); end
        @(posedge clk); #1 rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus_b.done === 1'b1) dones++;
        end
        vectors++; if (dones !== 0) begin errors++; $display("FAIL mid_reset_no_done got %0d pulses exp 0", dones); end
        run_b(16'h0300, 16'h0100, 2'd2, 1'b0, lat, b0);
        vectors++; if (bus_b.y !== {16'h0080, 16'h0080, 16'h0080}) begin errors++; $display("FAIL cleared_weights got %h exp 008000800080", bus_b.y); end
        vectors++; if (lat !== 9) begin errors++; $display("FAIL post_reset_latency got %0d exp 9", lat); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_identity_relu();
        test_truncation();
        test_overflow();
        test_hsig();
        test_handshake();
        test_write_with_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nnl_dense_seq.md
Name: nnl_dense_seq

Overview:
- Parametrised, time-multiplexed fixed-point dense layer: y[i] = act(sum_j W[i][j]*x[j] + b[i]) for N inputs and M outputs.
- Generalises the fixed 2-4-1 float net to arbitrary width, fan-in, fan-out and selectable activation.
- Uses one MAC datapath, a register-file weight store and a start/done handshake.
- Instances chain to build multi-layer nets: one layer's y feeds the next layer's x.

Parameters:
- WIDTH, 16, data word width; signed two's complement.
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC); must satisfy FRAC <= WIDTH-2.
- N, 2, inputs per neuron (fan-in), >= 1.
- M, 4, neurons (outputs), >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin one layer evaluation; sampled only when busy=0.
- x  in  N*WIDTH  input vector; x[j] is bits [j*WIDTH +: WIDTH]; latched on the accepted start.
- act_sel  in  2  activation select; latched on the accepted start.
- w_we  in  1  weight/bias write enable.
- w_addr  in  clog2(M*(N+1))  row-major address i*(N+1)+j; j=N is bias b[i].
- w_data  in  WIDTH  weight/bias value (Q format).
- y  out  M*WIDTH  output vector; y[i] is bits [i*WIDTH +: WIDTH].
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; y=0, busy=0, done=0, accumulator=0; all weights and biases cleared to 0. A reset mid-evaluation aborts it immediately; no done pulse is produced.
- States: IDLE, MAC, FIN.
- IDLE: on edge E0 with start=1:
  - latch x and act_sel;
  - acc <= sign-extended b[0] << FRAC;
  - i=0, j=0; busy<=1; go to MAC.
- MAC: each edge acc += W[i][j]*x[j] (full 2*WIDTH product, 2*FRAC fractional bits); j++. After the edge with j=N-1, go to FIN.
- FIN, one edge:
  - y[i] <= narrow(act(acc >>> FRAC)), arithmetic shift, truncating toward minus infinity;
  - if i<M-1: acc <= b[i+1] << FRAC, i++, j=0, go to MAC;
  - else go to IDLE, busy<=0, done<=1.
- Latency: done rises exactly M*(N+1) edges after E0 and stays high for one cycle.
- Accumulator width: 2*WIDTH + clog2(N+1); it never overflows internally.
- act_sel:
  - 0 identity;
  - 1 ReLU (negative -> 0);
  - 2 hard-sigmoid: clamp(v/4 + 0.5, 0, 1.0);
  - 3 step (v >= 0 -> 1.0, else 0).
  - 1.0 = 1 << FRAC.
- Handshake rules:
  - start while busy=1 is ignored.
  - start in the cycle done=1 is accepted (state is already IDLE).
  - y holds its previous values until each y[i] is overwritten in its own FIN edge. Only the complete y vector is valid, and only from the done pulse until the next accepted start.
- Weight writes:
  - accepted only when busy=0;
  - w_we while busy=1 is dropped silently;
  - w_addr >= M*(N+1) is ignored;
  - a write and start on the same IDLE edge: the write lands and the evaluation uses the old value at that address.

Optional Feature:
- Macro NNL_SAT_EN.
- Defined: narrow() saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Undefined: narrow() keeps the low WIDTH bits (wrap-around).
- Activation modes 2 and 3 are in range either way.

Decomposition:
- Shared package nnl_pkg holds:
  - act_sel encodings ACT_ID, ACT_RELU, ACT_HSIG, ACT_STEP;
  - state encodings;
  - a clog2 function.
- One natural sub-module: nnl_act, combinational. It takes the shifted accumulator and act_sel and returns the narrowed WIDTH-bit result. It contains the activation and the NNL_SAT_EN saturation logic.
- The sequencer, MAC and weight store stay in nnl_dense_seq.

Test Plan:
- Step mode: WIDTH=16, FRAC=8, N=2, M=1, W=[0x0100,0x0100], b=0xFF80 (-0.5), act_sel=3.
  - x=(0,0) -> y=0x0000.
  - x=(0x0100,0) -> y=0x0100.
  - x=(0x0100,0x0100) -> y=0x0100.
  - done on the 3rd edge after start.
- Identity mode, same weights, act_sel=0, x=(0x0100,0x0100) -> y=0x0180. ReLU with b=0xFC00 (-4.0) -> y=0x0000.
- Overflow, act_sel=0, W=[0x0100,0x0100], b=0, x=(0x6400,0x6400) (100.0 each):
  - NNL_SAT_EN defined -> y=0x7FFF;
  - undefined -> y=0xC800.
- Handshake, M=3, N=2:
  - done on the 9th edge after start;
  - start pulses and w_we writes issued mid-run have no effect;
  - start in the done cycle begins a new run, and busy stays high.
- Reset: assert rst_n=0 at edge 4 of a run -> y=0, busy=0, no done; all weights read back as 0 (next run gives y=act(0)).
- Hard-sigmoid, act_sel=2, single weight 0x0100, b=0:
  - x=0x0000 -> 0x0080;
  - x=0x0400 -> 0x0100;
  - x=0xF800 -> 0x0000.
